uart_rx_monitor: RTL
====================

# uart_rx_monitor

Serial-to-byte receiver sitting directly downstream of the SoC top-level `uart_txd` pin in the Xilinx verification bench. It is synthesizable so it can also sit in fabric beside the SoC. It oversamples the 8N1 line, recovers bytes and flags framing errors, then buffers bytes in a small FIFO with a valid/ready handshake. A checker or scoreboard consumes bytes from that FIFO without bit-level timing knowledge.

## Interface
Parameters:
- `CYCLES_PER_BIT`, default 217: `sys_clk` cycles per UART bit (25 MHz / 115200). Legal range ≥ 4.
- `FIFO_DEPTH`, default 16: byte FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `sys_reset`  in  1  synchronous, active-high reset.
- `uart_rxd`  in  1  serial line, idle high; bench connects DUT `uart_txd` here.
- `rx_data`  out  8  byte at FIFO head; reset 0x00.
- `rx_valid`  out  1  FIFO non-empty; reset 0.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse on bad stop bit; reset 0.
- `overflow`  out  1  sticky, byte dropped on full FIFO; cleared only by reset; reset 0.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy; reset 0.

## Operation
- Input path: two-flop synchronizer, both flops reset to 1. `rxd_s` is the second flop; `rxd_q` is `rxd_s` delayed one cycle.
- FSM states IDLE, START, DATA, STOP; reset state IDLE.
- IDLE → START on falling edge (`rxd_q`=1, `rxd_s`=0); bit counter loads 0.
- START: at count CYCLES_PER_BIT/2 − 1 (integer division), sample `rxd_s`.
  - If sample = 1, it is a glitch: go to IDLE, no flag.
  - If sample = 0, go to DATA with count cleared and bit index 0.
- DATA: sample at count CYCLES_PER_BIT − 1, then clear count.
  - Shift sample into MSB of an 8-bit shift register, so bytes are assembled LSB first.
  - After bit index 7, go to STOP.
- STOP: sample at count CYCLES_PER_BIT − 1, then return to IDLE in the same edge.
  - Sample = 1: push shift register into FIFO.
  - Sample = 0: pulse `frame_err` for the next cycle and discard the byte.
  - After a low stop bit, a new start requires the line to go high and then fall again.
- FIFO is first-word-fall-through:
  - `rx_data` = head entry; `rx_valid` = count ≠ 0.
  - Pop on `rx_valid && rx_ready`.
- Push while full:
  - With a simultaneous pop: push accepted, count unchanged.
  - Without a pop: byte dropped and `overflow` set.
- Simultaneous push and pop at non-full, non-empty: count unchanged, order preserved.
- `sys_reset` mid-frame: FSM to IDLE, FIFO emptied, synchronizer to 1, all outputs to reset values on the next edge. A frame in flight is lost.

## Timing
- Synchronizer latency: 2 cycles from `uart_rxd` to `rxd_s`.
- Mid-bit sampling: data bit k is sampled (CYCLES_PER_BIT/2) + (k+1)·CYCLES_PER_BIT cycles after the falling edge reaches `rxd_s`.
- Byte ready: `rx_valid` rises 1 cycle after the stop-bit sample edge, about 9.5·CYCLES_PER_BIT + 3 cycles after the line falls.
- `frame_err`: high exactly 1 cycle, aligned with the cycle `rx_valid` would have risen.
- Bit counter width: $clog2(CYCLES_PER_BIT) bits, no wrap beyond CYCLES_PER_BIT − 1.
- FIFO pointers: $clog2(FIFO_DEPTH) bits, wrap naturally. Count is one bit wider.
- Back-to-back frames are received with no idle gap: the STOP→IDLE return lands 0.5 bit before the next start edge.
- Combinational paths: none from `rx_ready` to any output except through FIFO registers.

## Structure
- Package `uart_mon_pkg`:
  - FSM state enum `uart_mon_state_t` (IDLE, START, DATA, STOP).
  - Default `CYCLES_PER_BIT` and `FIFO_DEPTH` constants.
  - Data width constant 8.
- Sub-module `uart_mon_fifo`: parameterized synchronous FWFT FIFO with push/pop/full/empty/count. It implements the overflow rule and is instantiated once.
- Top holds the synchronizer, FSM, counters and shift register.

## Test plan
- Send 0x55, `rx_ready`=1 → single `rx_valid` beat with 0x55, rising 9.5·217+3 ±1 cycles after the line falls; `frame_err` stays 0.
- Drive `uart_rxd` low for 50 cycles, then high → no byte, no `frame_err`, FSM back in IDLE.
- Send 0xA5 with stop bit driven low → `frame_err` pulses for exactly 1 cycle, `fifo_count` stays 0. Then send 0x3C → 0x3C received.
- `rx_ready`=0, send 17 bytes 0x00..0x10 → `fifo_count`=16 and `overflow`=1. Draining yields 0x00..0x0F in order; 0x10 is absent.
- Assert `sys_reset` for 1 cycle during DATA bit 3 of 0xFF → next cycle all outputs at reset values. Then send 0xC3 → received intact.
- 8 back-to-back frames 0x01..0x08 with no idle bits and `rx_ready` toggled every cycle → all 8 received in order, no `overflow`, no `frame_err`.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types and defaults for the UART receive monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_mon_pkg;

  localparam int DATA_W             = 8;
  localparam int CYCLES_PER_BIT_DEF = 217;  // 25 MHz / 115200 baud
  localparam int FIFO_DEPTH_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_mon_state_t;

endpackage

// File: rtl/uart_mon_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow on a dropped push.
// Latency: a push is visible at head_data one cycle later; a pop frees the head on the same edge.
// Backpressure: push while full is accepted only with a simultaneous pop, otherwise dropped.
// Ports: clk/reset (sync, active high); push/push_data write side; pop read side;
//        head_data/empty/count status; overflow sticky drop flag.
module uart_mon_fifo
  import uart_mon_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being popped is the one the write lands in, so a
  // simultaneous pop makes room.
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the output has a defined idle value.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count <= count - (AW+1)'(1);
      end
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: oversampled line -> bytes in a FWFT FIFO, with framing-error pulse.
// Latency: byte valid ~9.5 bit times + 3 cycles after the start edge on uart_rxd.
// Backpressure: rx_valid/rx_ready on the FIFO head; bytes arriving while full are dropped (sticky overflow).
// Ports: sys_clk, sys_reset (sync, active high); uart_rxd serial in (idle high);
//        rx_data/rx_valid/rx_ready byte stream; frame_err pulse; overflow sticky; fifo_count occupancy.
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset,
  input  logic                          uart_rxd,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);

  logic              rxd_m;
  logic              rxd_s;
  logic              rxd_q;
  uart_mon_state_t   state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              push;
  logic              fifo_empty;

  // Line synchronizer; resets to the idle level so reset never looks like a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
      rxd_q <= rxd_s;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Edge-triggered start: a line stuck low after a bad stop bit
          // must return high before another frame is accepted.
          if (rxd_q && !rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_s ? IDLE : DATA;  // high at mid-start means glitch
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[DATA_W-1:1]};  // LSB arrives first
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop gives half a bit of slack before a
          // back-to-back start edge.
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            state     <= IDLE;
            frame_err <= !rxd_s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push on the stop-sample edge itself so the byte is valid the next cycle.
  assign push = (state == STOP) && (cnt == BIT_LAST) && rxd_s;

  uart_mon_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (sys_clk),
    .reset     (sys_reset),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_valid && rx_ready),
    .head_data (rx_data),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign rx_valid = !fifo_empty;

endmodule
